// File: rtl/zoran_nios_mem_loader.sv
// Boot-image loader for the Nios on-chip RAM: packs a byte stream into
// little-endian words, writes them from word 0, then re-reads and checksums.
module zoran_nios_mem_loader #(
    parameter int DEPTH  = 5120,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] len;
    logic [CW-1:0] widx;
    logic [CW-1:0] nidx;
    logic [CW-1:0] req_len;
    logic [1:0]    bcnt;
    logic [23:0]   pack;
    logic [31:0]   racc;
    logic [31:0]   racc_next;
    logic          take;

    assign mem_byteenable = 4'hF;
    assign mem_clken      = ~reset;
    assign mem_reset_req  = reset;
    assign take           = s_valid & s_ready;
    assign nidx           = widx + 1'b1;
    assign req_len        = {1'b0, length_words};
    assign racc_next      = racc + mem_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            len            <= '0;
            widx           <= '0;
            bcnt           <= '0;
            pack           <= '0;
            racc           <= '0;
            s_ready        <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
        end else begin
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        len      <= req_len;
                        error    <= 1'b0;
                        checksum <= '0;
                        widx     <= '0;
                        bcnt     <= '0;
                        busy     <= 1'b1;
                        if (req_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (req_len > DEPTH_C) begin
                            error <= 1'b1;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_FILL;
                            s_ready <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (take) begin
                        bcnt <= bcnt + 2'd1;
                        // shifting in from the top leaves byte 0 in [7:0]
                        pack <= {s_data, pack[23:8]};
                        if (bcnt == 2'd3) begin
                            s_ready        <= 1'b0;
                            state          <= S_WRITE;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_address    <= widx[ADDR_W-1:0];
                            mem_writedata  <= {s_data, pack};
                        end
                    end
                end
                S_WRITE: begin
                    checksum <= checksum + mem_writedata;
                    if (widx == len - 1'b1) begin
                        state          <= S_VERIFY;
                        widx           <= '0;
                        racc           <= '0;
                        mem_chipselect <= 1'b1;
                        mem_address    <= '0;
                    end else begin
                        widx    <= nidx;
                        state   <= S_FILL;
                        s_ready <= 1'b1;
                    end
                end
                S_VERIFY: begin
                    widx <= nidx;
                    // read data lags its address by one cycle
                    if (widx != '0) racc <= racc_next;
                    if (nidx < len) begin
                        mem_chipselect <= 1'b1;
                        mem_address    <= nidx[ADDR_W-1:0];
                    end
                    if (widx == len) begin
                        if (racc_next != checksum) error <= 1'b1;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zoran_nios_mem_loader.sv
// Randomized self-checking bench for zoran_nios_mem_loader with a
// behavioural memory model and an image-level reference model.
module tb_zoran_nios_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] length_words;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        mem_reset_req;
    logic [31:0] mem_readdata = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:5119];
    logic [7:0]  bytes_q [$];
    logic [12:0] wl_addr [$];
    logic [31:0] wl_data [$];
    int          cs_cnt = 0;
    int          corrupt_addr = -1;

    always #5 clk = ~clk;

    zoran_nios_mem_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .length_words(length_words),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .mem_address(mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_clken(mem_clken),
        .mem_reset_req(mem_reset_req),
        .mem_readdata(mem_readdata),
        .busy(busy),
        .done(done),
        .error(error),
        .checksum(checksum)
    );

    // Single-port RAM, one-cycle read latency, optional readback corruption.
    always @(posedge clk) begin
        if (mem_chipselect) cs_cnt++;
        if (mem_chipselect && mem_write) begin
            if (mem_address < 13'd5120) mem[mem_address] <= mem_writedata;
            wl_addr.push_back(mem_address);
            wl_data.push_back(mem_writedata);
        end
        if (mem_chipselect && !mem_write && mem_address < 13'd5120)
            mem_readdata <= mem[mem_address] ^
                ((int'(mem_address) == corrupt_addr) ? 32'h0000_0100 : 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wl_addr.delete();
        wl_data.delete();
        cs_cnt = 0;
    endtask

    task automatic fill_bytes(input int n, input bit ones);
        bytes_q.delete();
        for (int i = 0; i < n; i++)
            bytes_q.push_back(ones ? 8'hFF : 8'($urandom));
    endtask

    // Drive one load and compare everything against the image-level model.
    task automatic run_load(input string name, input int len, input bit toggle);
        logic [31:0] ew [$];
        logic [31:0] sum;
        bit          ok_len;
        bit          exp_err;
        int          exp_cyc;
        int          cyc;
        int          bi;
        int          done_cyc;
        int          budget;
        bit          busy_ok;

        ok_len = (len >= 1) && (len <= 5120);
        sum = '0;
        if (ok_len) begin
            for (int w = 0; w < len; w++) begin
                ew.push_back({bytes_q[4*w+3], bytes_q[4*w+2],
                              bytes_q[4*w+1], bytes_q[4*w]});
                sum += ew[w];
            end
        end
        exp_err = (len > 5120) ||
                  (ok_len && corrupt_addr >= 0 && corrupt_addr < len);
        exp_cyc = ok_len ? (toggle ? -1 : 6*len + 2) : 1;
        budget  = 20*len + 50;
        if (len > 5120) budget = 50;

        clear_logs();
        start = 1'b1;
        length_words = 13'(len);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        bi = 0;
        done_cyc = -1;
        busy_ok = 1'b1;
        while (done_cyc < 0 && cyc < budget) begin
            s_valid = (bi < bytes_q.size()) && (!toggle || (cyc % 2) == 1);
            s_data  = s_valid ? bytes_q[bi] : 8'h00;
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) done_cyc = cyc;
            if (s_valid && s_ready) bi++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        if (exp_cyc >= 0) check({name, "_done_cycle"}, done_cyc, exp_cyc);
        check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_checksum"}, checksum, sum);
        check({name, "_n_writes"}, wl_addr.size(), ok_len ? len : 0);
        check({name, "_n_access"}, cs_cnt, ok_len ? 2*len : 0);
        for (int w = 0; w < wl_addr.size() && w < ew.size(); w++) begin
            check({name, "_waddr"}, 32'(wl_addr[w]), w);
            check({name, "_wdata"}, wl_data[w], ew[w]);
        end
        @(negedge clk);
        check({name, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_s_ready"}, 32'(s_ready), 32'd0);
        check({name, "_cs_wr"}, 32'({mem_chipselect, mem_write}), 32'd0);
        check({name, "_addr"}, 32'(mem_address), 32'd0);
        check({name, "_wdata"}, mem_writedata, 32'd0);
        check({name, "_checksum"}, checksum, 32'd0);
        check({name, "_be"}, 32'(mem_byteenable), 32'hF);
    endtask

    initial begin
        int bi;
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        length_words = '0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_high", 32'({mem_reset_req, mem_clken}), 32'b10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        check("rst_req_low", 32'({mem_reset_req, mem_clken}), 32'b01);
        @(posedge clk); #1;

        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load("two", 2, 1'b0);
        check("two_sum_const", checksum, 32'hCCAA8866);
        check("two_w1_const", wl_data.size() > 1 ? wl_data[1] : 32'h0,
              32'h88776655);

        bytes_q.delete();
        run_load("zero", 0, 1'b0);
        run_load("toolong", 5121, 1'b0);
        check("toolong_err_const", 32'(error), 32'd1);

        fill_bytes(12, 1'b0);
        corrupt_addr = 1;
        run_load("corrupt", 3, 1'b1);
        corrupt_addr = -1;

        for (int t = 0; t < 5; t++) begin
            int len;
            len = int'($urandom_range(1, 9));
            fill_bytes(4*len, 1'b0);
            corrupt_addr = ($urandom_range(0, 2) == 0) ?
                           int'($urandom_range(0, 9)) : -1;
            run_load("rand", len, 1'($urandom_range(0, 1)));
            corrupt_addr = -1;
        end

        fill_bytes(16, 1'b0);
        clear_logs();
        start = 1'b1;
        length_words = 13'd4;
        @(posedge clk); #1;
        start = 1'b0;
        bi = 0;
        cyc = 0;
        while (bi < 6 && cyc < 100) begin
            s_valid = 1'b1;
            s_data = bytes_q[bi];
            @(negedge clk);
            if (s_ready) bi++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check("midrst_bytes", bi, 6);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'({mem_reset_req, mem_clken}), 32'b10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        repeat (5) @(posedge clk);
        #1;
        check("midrst_n_access", cs_cnt, 1);
        check("midrst_w0", wl_data.size() > 0 ? wl_data[0] : 32'h0,
              {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]});
        fill_bytes(16, 1'b0);
        run_load("after_rst", 4, 1'b0);

        fill_bytes(4*5120, 1'b1);
        run_load("full", 5120, 1'b0);
        check("full_sum_const", checksum, 32'hFFFFEC00);
        check("full_last_addr",
              wl_addr.size() > 0 ? 32'(wl_addr[wl_addr.size()-1]) : 32'h0,
              32'd5119);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
